// File: rtl/systolic_tile_ctrl_if.sv
// Scheduler, operand SRAM, PE grid and result-stream signals of systolic_tile_ctrl.
// TPU_CTRL_ACCUM_EN adds the accumulate input (sampled with start).
interface systolic_tile_ctrl_if #(
    parameter int N  = 4,
    parameter int AW = 8
);
    localparam int RW = $clog2(N);

    // Result stream: a row moves on a cycle with res_valid & res_ready; once
    // raised, res_valid and res_data/res_row hold until that transfer happens.
    logic              start;
    logic [AW-1:0]     k_len;
`ifdef TPU_CTRL_ACCUM_EN
    logic              accumulate;
`endif
    logic              busy;
    logic              done;
    logic              a_rd_en;
    logic              b_rd_en;
    logic [AW-1:0]     a_rd_addr;
    logic [AW-1:0]     b_rd_addr;
    logic [8*N-1:0]    a_rd_data;
    logic [8*N-1:0]    b_rd_data;
    logic [8*N-1:0]    arr_a_in;
    logic [8*N-1:0]    arr_b_in;
    logic              arr_clear;
    logic [RW-1:0]     c_row_sel;
    logic [16*N-1:0]   c_row_data;
    logic              res_valid;
    logic              res_ready;
    logic [16*N-1:0]   res_data;
    logic [RW-1:0]     res_row;
    logic [2:0]        dbg_state;

`ifdef TPU_CTRL_ACCUM_EN
    modport master (
        input  start, k_len, accumulate, a_rd_data, b_rd_data, c_row_data, res_ready,
        output busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_a_in, arr_b_in,
               arr_clear, c_row_sel, res_valid, res_data, res_row, dbg_state
    );
    modport slave (
        output start, k_len, accumulate, a_rd_data, b_rd_data, c_row_data, res_ready,
        input  busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_a_in, arr_b_in,
               arr_clear, c_row_sel, res_valid, res_data, res_row, dbg_state
    );
`else
    modport master (
        input  start, k_len, a_rd_data, b_rd_data, c_row_data, res_ready,
        output busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_a_in, arr_b_in,
               arr_clear, c_row_sel, res_valid, res_data, res_row, dbg_state
    );
    modport slave (
        output start, k_len, a_rd_data, b_rd_data, c_row_data, res_ready,
        input  busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_a_in, arr_b_in,
               arr_clear, c_row_sel, res_valid, res_data, res_row, dbg_state
    );
`endif
endinterface

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for an N x N output-stationary FP8 systolic tile: clear, skewed feed,
// flush, row-by-row drain. TPU_CTRL_ACCUM_EN enables K-split accumulation.
module systolic_tile_ctrl #(
    parameter int N  = 4,
    parameter int AW = 8
) (
    input logic                 clk,
    input logic                 rst,
    systolic_tile_ctrl_if.master bus
);
    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   k_reg;
    logic [AW-1:0]   k_cnt;
    logic [FW-1:0]   flush_cnt;
    logic [RW-1:0]   row_cnt;
    logic            done_q;
    logic            accum_q;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            feed_last;
    logic            row_accept;
    logic [8*N-1:0]  skew_a;
    logic [8*N-1:0]  skew_b;

    assign feed_last  = (k_cnt == k_reg - AW'(1));
    assign row_accept = (state == DRAIN) && bus.res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = CLEAR;
            end
            CLEAR: begin
                rd_en     = (k_reg != '0);
                state_nxt = (k_reg != '0) ? FEED : FLUSH;
            end
            FEED: begin
                // Address k+1 is prefetched so its data lands on the next feed cycle.
                if (!feed_last) begin
                    rd_en   = 1'b1;
                    rd_addr = k_cnt + AW'(1);
                end else begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (row_accept && row_cnt == ROW_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg     <= '0;
            accum_q   <= 1'b0;
            k_cnt     <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                k_reg <= bus.k_len;
`ifdef TPU_CTRL_ACCUM_EN
                accum_q <= bus.accumulate;
`else
                accum_q <= 1'b0;
`endif
            end
            k_cnt     <= (state == FEED) ? k_cnt + AW'(1) : '0;
            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
            if (row_accept) begin
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
            end
            done_q <= row_accept && (row_cnt == ROW_LAST);
        end
    end

    // Zeros outside FEED keep the accumulators unchanged during flush and drain.
    assign skew_a = (state == FEED) ? bus.a_rd_data : '0;
    assign skew_b = (state == FEED) ? bus.b_rd_data : '0;

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign bus.arr_a_in[7:0] = skew_a[7:0];
            assign bus.arr_b_in[7:0] = skew_b[7:0];
        end else begin : g_delay
            logic [7:0] a_sr [0:i-1];
            logic [7:0] b_sr [0:i-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else begin
                    a_sr[0] <= skew_a[8*i +: 8];
                    b_sr[0] <= skew_b[8*i +: 8];
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end
            assign bus.arr_a_in[8*i +: 8] = a_sr[i-1];
            assign bus.arr_b_in[8*i +: 8] = b_sr[i-1];
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.a_rd_en   = rd_en;
    assign bus.b_rd_en   = rd_en;
    assign bus.a_rd_addr = rd_addr;
    assign bus.b_rd_addr = rd_addr;
    assign bus.arr_clear = (state == CLEAR) && !accum_q;
    assign bus.c_row_sel = row_cnt;
    assign bus.res_row   = row_cnt;
    assign bus.res_valid = (state == DRAIN);
    assign bus.res_data  = (state == DRAIN) ? bus.c_row_data : '0;
    assign bus.dbg_state = state;
endmodule
